// File: rtl/led_pkg.sv
// led_pkg: shared encodings for the LED sequencer
//  MODE_* : walk modes held in CTRL[3:2]
//  REG_*  : per-channel register offsets (addr[1:0])
//  CTRL_*, STAT_* : bit positions inside CTRL and STAT
//  ch_state_t : per-channel walker state
package led_pkg;
    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_LOOP   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_POS     = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_STAT    = 2'd3;
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_MODE  = 2;
    localparam int STAT_DONE  = 0;
    typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_DONE} ch_state_t;
endpackage

// File: rtl/led_walker_core.sv
// led_walker_core: one channel's walker FSM, tick counter, position, direction and sticky done
//  i_clk, i_reset_n       : clock, synchronous active-low reset
//  i_start/i_stop/i_clear : one-cycle command pulses (stop has priority over start)
//  i_mode/i_pos/i_period  : configuration captured on start
//  o_busy, o_done         : walking, sticky completion flag
//  o_cur, o_leds          : current position and its one-hot LED image
module led_walker_core
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PW       = 16,
    localparam int LW      = $clog2(NUM_LEDS)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_clear,
    input  logic [1:0]          i_mode,
    input  logic [LW-1:0]       i_pos,
    input  logic [PW-1:0]       i_period,
    output logic                o_busy,
    output logic                o_done,
    output logic [LW-1:0]       o_cur,
    output logic [NUM_LEDS-1:0] o_leds
);
    localparam logic [LW-1:0] LAST = LW'(NUM_LEDS - 1);

    ch_state_t     state, state_d;
    logic [PW-1:0] tick, period_q;
    logic [LW-1:0] cur, cur_step;
    logic [1:0]    mode_q;
    logic          dir, go_up, tick_hit, finish, done;

    // Period and mode are snapshotted at start so bus writes during a walk
    // only apply to the next one.
    always_comb begin
        tick_hit = tick == period_q;
        finish   = tick_hit && !mode_q[1] && (mode_q == MODE_UP ? cur == LAST : cur == '0);
        go_up    = mode_q == MODE_BOUNCE ? (dir ? cur != LAST : cur == '0) : mode_q != MODE_DOWN;
        cur_step = (mode_q == MODE_LOOP && cur == LAST) ? '0 : go_up ? cur + 1'b1 : cur - 1'b1;
    end

    always_comb begin
        state_d = i_stop            ? CH_IDLE :
                  i_start           ? CH_RUN  :
                  state == CH_DONE  ? CH_IDLE :
                  (state == CH_RUN && finish) ? CH_DONE : state;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= CH_IDLE;
        else            state <= state_d;
    end

    // The end LED is held for its full period; the position is only stepped
    // while staying in RUN, so it never leaves 0..NUM_LEDS-1.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tick     <= '0;
            period_q <= '0;
            cur      <= '0;
            mode_q   <= MODE_UP;
            dir      <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= (state == CH_DONE) | (done & ~i_clear);
            if (i_start && !i_stop) begin
                tick     <= '0;
                period_q <= i_period;
                cur      <= i_pos;
                mode_q   <= i_mode;
                dir      <= i_mode != MODE_DOWN;
            end else if (state_d == CH_RUN) begin
                tick <= tick_hit ? '0 : tick + 1'b1;
                if (tick_hit) begin
                    cur <= cur_step;
                    dir <= go_up;
                end
            end
        end
    end

    always_comb begin
        o_busy = state == CH_RUN;
        o_done = done;
        o_cur  = cur;
        o_leds = state == CH_RUN ? (NUM_LEDS'(1) << cur) : '0;
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: multi-channel LED walker behind a Wishbone-pipelined slave port
//  i_clk, i_reset_n            : clock, synchronous active-low reset
//  i_cyc/i_stb/i_we/i_addr/i_data : bus request, i_addr = {channel, reg[1:0]}
//  o_ack/o_stall/o_data        : registered ack, never stalls, read data with ack
//  o_leds                      : channel c on [c*NUM_LEDS +: NUM_LEDS]
//  o_irq                       : per-channel sticky done
module led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int NUM_CH   = 4,
    parameter int PW       = 16,
    parameter int DW       = 32,
    localparam int AW      = $clog2(NUM_CH) + 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_cyc,
    input  logic                       i_stb,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_addr,
    input  logic [DW-1:0]              i_data,
    output logic                       o_ack,
    output logic                       o_stall,
    output logic [DW-1:0]              o_data,
    output logic [NUM_CH*NUM_LEDS-1:0] o_leds,
    output logic [NUM_CH-1:0]          o_irq
);
    localparam int LW = $clog2(NUM_LEDS);
    localparam logic [LW-1:0] LAST = LW'(NUM_LEDS - 1);

    logic          accept;
    logic [AW-1:0] ch_idx;
    logic [1:0]    reg_sel;
    logic [DW-1:0] rdata;
    logic [DW-1:0] ch_rd [NUM_CH];

    assign accept  = i_cyc & i_stb;
    assign ch_idx  = i_addr >> 2;
    assign reg_sel = i_addr[1:0];
    assign o_stall = 1'b0;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic          wr, busy, done;
            logic [LW-1:0] pos_r, cur;
            logic [PW-1:0] per_r;
            logic [1:0]    mode_r;

            // Channel indices with no channel behind them never match, so
            // such writes fall away and reads see the zero default.
            assign wr = accept && i_we && ch_idx == AW'(c);

            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    mode_r <= MODE_UP;
                    pos_r  <= '0;
                    per_r  <= '0;
                end else if (wr) begin
                    if (reg_sel == REG_CTRL)   mode_r <= i_data[CTRL_MODE +: 2];
                    if (reg_sel == REG_POS)    pos_r  <= i_data >= DW'(NUM_LEDS) ? LAST : i_data[LW-1:0];
                    if (reg_sel == REG_PERIOD) per_r  <= i_data[PW-1:0];
                end
            end

            led_walker_core #(.NUM_LEDS(NUM_LEDS), .PW(PW)) u_core (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_start   (wr && reg_sel == REG_CTRL && i_data[CTRL_START] && !i_data[CTRL_STOP]),
                .i_stop    (wr && reg_sel == REG_CTRL && i_data[CTRL_STOP]),
                .i_clear   (wr && reg_sel == REG_STAT && i_data[STAT_DONE]),
                .i_mode    (i_data[CTRL_MODE +: 2]),
                .i_pos     (pos_r),
                .i_period  (per_r),
                .o_busy    (busy),
                .o_done    (done),
                .o_cur     (cur),
                .o_leds    (o_leds[c*NUM_LEDS +: NUM_LEDS])
            );

            assign o_irq[c] = done;
            assign ch_rd[c] = reg_sel == REG_CTRL   ? DW'({mode_r, done, busy}) :
                              reg_sel == REG_POS    ? DW'(busy ? cur : pos_r)   :
                              reg_sel == REG_PERIOD ? DW'(per_r)                : DW'(done);
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) rdata = ch_idx == AW'(i) ? ch_rd[i] : rdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_ack  <= 1'b0;
            o_data <= '0;
        end else begin
            o_ack  <= accept;
            o_data <= (accept && !i_we) ? rdata : '0;
        end
    end
endmodule
